inst_fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle MIPS-style CPU.
- Holds a 32-bit program counter (PC) and a read-only instruction memory preloaded with a fixed program.
- Presents the instruction word at the current PC on Inst_code.
- Advances the PC every clock: PC+4 normally, or to the J-type target when the fetched word is an unconditional jump.

---
 rtl/inst_fetch_unit.sv | 52 +++++
 tb/tb_inst_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC register, combinational instruction ROM holding a
// fixed program, and next-PC selection between PC+4 and the J-type target.
module inst_fetch_unit #(
  parameter int          ADDR_BITS = 6,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Inst_code
);

  localparam int         ROM_WORDS = 1 << ADDR_BITS;
  localparam logic [5:0] OP_J      = 6'b000010;

  // Fixed program; every word outside the listed ones reads as a nop.
  function automatic logic [31:0] rom_init(input int idx);
    case (idx)
      0:       rom_init = 32'h2001_0001; // addi $1,$0,1
      1:       rom_init = 32'h2002_0002; // addi $2,$0,2
      2:       rom_init = 32'h0022_1820; // add  $3,$1,$2
      3:       rom_init = 32'h0062_2022; // sub  $4,$3,$2
      4:       rom_init = 32'h0800_0000; // j    0x00000000
      default: rom_init = 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] rom [ROM_WORDS];

  for (genvar i = 0; i < ROM_WORDS; i++) begin : g_rom
    assign rom[i] = rom_init(i);
  end

  // Byte offset bits and everything above the ROM window are dropped, so
  // addresses past the end alias back onto the start of the program.
  assign Inst_code = rom[pc[ADDR_BITS+1:2]];

  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    if (Inst_code[31:26] == OP_J)
      next_pc = {pc_plus4[31:28], Inst_code[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= PC_RESET;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, sequential fetch, jump loop,
// mid-run reset, reset on the jump edge, and ROM address aliasing.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Inst_code;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W0 = 32'h2001_0001;
  localparam logic [31:0] W1 = 32'h2002_0002;
  localparam logic [31:0] W2 = 32'h0022_1820;
  localparam logic [31:0] W3 = 32'h0062_2022;
  localparam logic [31:0] W4 = 32'h0800_0000;

  logic [31:0] prog_words [5];
  logic [31:0] prog_pcs   [5];

  inst_fetch_unit #(.ADDR_BITS(6), .PC_RESET(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .Inst_code (Inst_code)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge and park on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dut.pc !== 32'h0 || Inst_code !== W0) begin
        n_fail++;
        $display("FAIL reset[%0d]: pc=%h inst=%h, expected pc=00000000 inst=%h", i, dut.pc, Inst_code, W0);
      end
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    for (int k = 1; k < 5; k++) begin
      step();
      n_checks++;
      if (dut.pc !== prog_pcs[k] || Inst_code !== prog_words[k]) begin
        n_fail++;
        $display("FAIL seq[%0d]: pc=%h inst=%h, expected pc=%h inst=%h", k, dut.pc, Inst_code, prog_pcs[k], prog_words[k]);
      end
    end
  endtask

  // Starts on the j instruction; three full passes of the 5-word loop.
  task automatic test_jump_loop();
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        n_checks++;
        if (dut.pc !== prog_pcs[k] || Inst_code !== prog_words[k]) begin
          n_fail++;
          $display("FAIL loop[%0d.%0d]: pc=%h inst=%h, expected pc=%h inst=%h", it, k, dut.pc, Inst_code, prog_pcs[k], prog_words[k]);
        end
      end
    end
  endtask

  // Starts on the j instruction (pc=0x10).
  task automatic test_midrun_reset();
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (dut.pc !== 32'hC || Inst_code !== W3) begin
      n_fail++;
      $display("FAIL mid_pre: pc=%h inst=%h, expected pc=0000000c inst=%h", dut.pc, Inst_code, W3);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (dut.pc !== 32'h0 || Inst_code !== W0) begin
      n_fail++;
      $display("FAIL mid_rst: pc=%h inst=%h, expected pc=00000000 inst=%h", dut.pc, Inst_code, W0);
    end
    step();
    n_checks++;
    if (dut.pc !== 32'h4 || Inst_code !== W1) begin
      n_fail++;
      $display("FAIL mid_restart: pc=%h inst=%h, expected pc=00000004 inst=%h", dut.pc, Inst_code, W1);
    end
  endtask

  // Starts at pc=4.
  task automatic test_reset_on_jump();
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (dut.pc !== 32'h10 || Inst_code !== W4) begin
      n_fail++;
      $display("FAIL rj_pre: pc=%h inst=%h, expected pc=00000010 inst=%h", dut.pc, Inst_code, W4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (dut.pc !== 32'h0 || Inst_code !== W0 || $isunknown(Inst_code)) begin
      n_fail++;
      $display("FAIL rj_rst: pc=%h inst=%h, expected pc=00000000 inst=%h", dut.pc, Inst_code, W0);
    end
    step();
    n_checks++;
    if (dut.pc !== 32'h4 || Inst_code !== W1) begin
      n_fail++;
      $display("FAIL rj_after: pc=%h inst=%h, expected pc=00000004 inst=%h", dut.pc, Inst_code, W1);
    end
  endtask

  task automatic test_alias();
    // Deposit 0x100 directly: aliases onto word 0.
    force dut.pc = 32'h100;
    #1;
    n_checks++;
    if (Inst_code !== W0) begin
      n_fail++;
      $display("FAIL alias_100: inst=%h, expected %h", Inst_code, W0);
    end
    release dut.pc;
    step();
    n_checks++;
    if (dut.pc !== 32'h104 || Inst_code !== W1) begin
      n_fail++;
      $display("FAIL alias_104: pc=%h inst=%h, expected pc=00000104 inst=%h", dut.pc, Inst_code, W1);
    end
    // Last ROM word (nop) rolls over to 0x100 without a jump.
    force dut.pc = 32'hFC;
    #1;
    n_checks++;
    if (Inst_code !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_fc: inst=%h, expected 00000000", Inst_code);
    end
    release dut.pc;
    step();
    n_checks++;
    if (dut.pc !== 32'h100 || Inst_code !== W0) begin
      n_fail++;
      $display("FAIL wrap_100: pc=%h inst=%h, expected pc=00000100 inst=%h", dut.pc, Inst_code, W0);
    end
    step();
    n_checks++;
    if (dut.pc !== 32'h104 || Inst_code !== W1) begin
      n_fail++;
      $display("FAIL wrap_104: pc=%h inst=%h, expected pc=00000104 inst=%h", dut.pc, Inst_code, W1);
    end
  endtask

  initial begin
    prog_words[0] = W0; prog_pcs[0] = 32'h00;
    prog_words[1] = W1; prog_pcs[1] = 32'h04;
    prog_words[2] = W2; prog_pcs[2] = 32'h08;
    prog_words[3] = W3; prog_pcs[3] = 32'h0C;
    prog_words[4] = W4; prog_pcs[4] = 32'h10;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_jump_loop();
    test_midrun_reset();
    test_reset_on_jump();
    test_alias();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
